// File: rtl/maze_level_engine.sv
// Maze-level core: per-pixel renderer plus player movement, wall collision,
// lives and win detection over a run-time table of path rectangles.
module maze_level_engine #(
  parameter int unsigned NUM_RECTS   = 11,
  parameter int unsigned PLAYER_SIZE = 25,
  parameter int unsigned STEP        = 5,
  parameter int unsigned TICK_DIV    = 1250000,
  parameter int unsigned START_X     = 33,
  parameter int unsigned START_Y     = 443,
  parameter int unsigned MAX_LIVES   = 3,
  parameter int unsigned HIT_TICKS   = 8
) (
  input  logic                    pixel_clk,
  input  logic                    resetSwitch,
  input  logic [9:0]              col,
  input  logic [8:0]              row,
  input  logic [3:0]              switches,
  input  logic [38*NUM_RECTS-1:0] path_rects,
  input  logic [37:0]             start_rect,
  input  logic [37:0]             finish_rect,
  output logic [3:0]              red,
  output logic [3:0]              green,
  output logic [3:0]              blue,
  output logic [9:0]              player_x,
  output logic [8:0]              player_y,
  output logic [2:0]              lives,
  output logic                    level_done,
  output logic                    game_over
);

  typedef enum logic [1:0] {StPlay, StHit, StWin, StOver} state_e;

  localparam int unsigned TickW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HitW   = $clog2(HIT_TICKS + 1);
  localparam logic [10:0] Step11 = 11'(STEP);
  localparam logic [10:0] Span11 = 11'(PLAYER_SIZE - 1);
  localparam logic [10:0] Size11 = 11'(PLAYER_SIZE);
  localparam logic [10:0] MaxX   = 11'd639;
  localparam logic [10:0] MaxY   = 11'd479;

  // All geometry is done in 11 bits so rx+w and ry+h never wrap.
  function automatic logic pt_in_rect(input logic [10:0] px, input logic [10:0] py,
                                      input logic [37:0] r);
    logic [10:0] rx, ry, rw, rh;
    rx = {1'b0, r[37:28]};
    ry = {2'b0, r[27:19]};
    rw = {1'b0, r[18:9]};
    rh = {2'b0, r[8:0]};
    return (px >= rx) && (px < rx + rw) && (py >= ry) && (py < ry + rh);
  endfunction

  function automatic logic pt_in_path(input logic [10:0] px, input logic [10:0] py,
                                      input logic [38*NUM_RECTS-1:0] rects);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < NUM_RECTS; i++) begin
      hit = hit | pt_in_rect(px, py, rects[38*i +: 38]);
    end
    return hit;
  endfunction

  state_e           state_q;
  logic [TickW-1:0] tick_q;
  logic [HitW-1:0]  hit_cnt_q;
  logic             move_tick;
  logic             want_move;
  logic [10:0]      cand_x, cand_y, cand_r, cand_b;
  logic             in_screen, in_finish, on_path;
  logic [10:0]      pix_x, pix_y, ply_x, ply_y;
  logic             on_player;
  logic [11:0]      pix_rgb;

  assign move_tick = (tick_q == TickW'(TICK_DIV - 1));
  assign want_move = |switches;

  // Candidate position for this tick; priority left > up > down > right.
  always_comb begin
    cand_x = {1'b0, player_x};
    cand_y = {2'b0, player_y};
    if (switches[3])      cand_x = cand_x - Step11;
    else if (switches[2]) cand_y = cand_y - Step11;
    else if (switches[1]) cand_y = cand_y + Step11;
    else if (switches[0]) cand_x = cand_x + Step11;
  end

  // Negative candidates wrap to large values, so one upper-bound test covers both.
  assign in_screen = (cand_x <= MaxX) && (cand_y <= MaxY);
  assign cand_r    = cand_x + Span11;
  assign cand_b    = cand_y + Span11;
  assign in_finish = pt_in_rect(cand_x, cand_y, finish_rect) &&
                     pt_in_rect(cand_r, cand_y, finish_rect) &&
                     pt_in_rect(cand_x, cand_b, finish_rect) &&
                     pt_in_rect(cand_r, cand_b, finish_rect);
  assign on_path   = pt_in_path(cand_x, cand_y, path_rects) &&
                     pt_in_path(cand_r, cand_y, path_rects) &&
                     pt_in_path(cand_x, cand_b, path_rects) &&
                     pt_in_path(cand_r, cand_b, path_rects);

  // Game FSM with tick divider, hit timer and registered status outputs.
  always_ff @(posedge pixel_clk) begin
    if (resetSwitch) begin
      state_q    <= StPlay;
      tick_q     <= '0;
      hit_cnt_q  <= '0;
      player_x   <= 10'(START_X);
      player_y   <= 9'(START_Y);
      lives      <= 3'(MAX_LIVES);
      level_done <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      level_done <= 1'b0;
      tick_q     <= move_tick ? '0 : tick_q + 1'b1;
      if (move_tick) begin
        unique case (state_q)
          StPlay: begin
            if (want_move) begin
              // Finish containment wins even where the pad is off the path.
              if (in_screen && in_finish) begin
                player_x   <= cand_x[9:0];
                player_y   <= cand_y[8:0];
                state_q    <= StWin;
                level_done <= 1'b1;
              end else if (in_screen && on_path) begin
                player_x <= cand_x[9:0];
                player_y <= cand_y[8:0];
              end else begin
                lives    <= lives - 3'd1;
                player_x <= 10'(START_X);
                player_y <= 9'(START_Y);
                if (lives == 3'd1) begin
                  state_q   <= StOver;
                  game_over <= 1'b1;
                end else begin
                  state_q   <= StHit;
                  hit_cnt_q <= '0;
                end
              end
            end
          end
          StHit: begin
            hit_cnt_q <= hit_cnt_q + 1'b1;
            if (hit_cnt_q + 1'b1 == HitW'(HIT_TICKS)) state_q <= StPlay;
          end
          StWin, StOver: ;
        endcase
      end
    end
  end

  // Pixel colour for the current beam position, first match wins.
  always_comb begin
    pix_x     = {1'b0, col};
    pix_y     = {2'b0, row};
    ply_x     = {1'b0, player_x};
    ply_y     = {2'b0, player_y};
    on_player = (pix_x >= ply_x) && (pix_x < ply_x + Size11) &&
                (pix_y >= ply_y) && (pix_y < ply_y + Size11);
    pix_rgb   = 12'h000;
    if (on_player) begin
      pix_rgb = (state_q == StHit || state_q == StOver) ? 12'hF00 : 12'hF0F;
    end else if (pt_in_rect(pix_x, pix_y, start_rect)) begin
      pix_rgb = 12'h0F0;
    end else if (pt_in_rect(pix_x, pix_y, finish_rect)) begin
      pix_rgb = 12'hF00;
    end else if (pt_in_path(pix_x, pix_y, path_rects)) begin
      pix_rgb = 12'hFFF;
    end
  end

  // Registered colour output, one cycle behind col/row.
  always_ff @(posedge pixel_clk) begin
    if (resetSwitch) begin
      {red, green, blue} <= 12'h000;
    end else begin
      {red, green, blue} <= pix_rgb;
    end
  end

endmodule
